// File: rtl/stream_pkg.sv
// Shared definitions for the stream width-conversion blocks.
//   DEFAULT_BEAT_W : default wide beat width (FIFO read side).
//   DEFAULT_WORD_W : default narrow word width (consumer side).
//   clog2_min1     : ceil(log2(n)) but never less than 1, so that index
//                    and counter registers always have at least one bit.
package stream_pkg;

  localparam int DEFAULT_BEAT_W = 128;
  localparam int DEFAULT_WORD_W = 32;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_word_unpacker.sv
// Wide-to-narrow stream unpacker sitting behind a FIFO read port.
// Each accepted IN_WIDTH beat is emitted as RATIO = IN_WIDTH/OUT_WIDTH
// words, least-significant word first. m_tlast marks the final word of
// every BEATS_PER_PKT-th beat.
//
// Ports:
//   rd_clk    in   clock, rising edge
//   rd_rst    in   synchronous active-high reset
//   s_tdata   in   IN_WIDTH input beat
//   s_tvalid  in   input beat valid
//   s_tready  out  input ready
//   m_tdata   out  OUT_WIDTH output word
//   m_tvalid  out  output word valid
//   m_tready  in   downstream ready
//   m_tlast   out  last word of packet (qualified by m_tvalid)
//   busy      out  a beat is held or a packet is partially emitted
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid and ready are both high. While valid is high and ready is
// low the sender keeps data/last stable. s_tready depends combinationally
// on m_tready so that the next beat can be loaded in the same cycle the
// last word of the current beat leaves (no bubble between beats).
module stream_word_unpacker
  import stream_pkg::*;
#(
  parameter int IN_WIDTH      = DEFAULT_BEAT_W,
  parameter int OUT_WIDTH     = DEFAULT_WORD_W,
  parameter int BEATS_PER_PKT = 2
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  input  logic [IN_WIDTH-1:0]  s_tdata,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  output logic [OUT_WIDTH-1:0] m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic                 busy
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = clog2_min1(RATIO);
  localparam int CNT_W = clog2_min1(BEATS_PER_PKT);
  localparam int N_SLOTS = 2 ** IDX_W;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(RATIO - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_PKT - 1);

  if ((OUT_WIDTH < 1) || (IN_WIDTH < OUT_WIDTH) || (IN_WIDTH % OUT_WIDTH != 0)) begin : g_bad_width
    $error("stream_word_unpacker: IN_WIDTH must be a positive multiple of OUT_WIDTH");
  end
  if (BEATS_PER_PKT < 1) begin : g_bad_pkt
    $error("stream_word_unpacker: BEATS_PER_PKT must be >= 1");
  end

  logic [IN_WIDTH-1:0]  hold;
  logic                 hold_valid;
  logic [IDX_W-1:0]     word_idx;
  logic [CNT_W-1:0]     beat_cnt;

  logic accept;
  logic fire;
  logic last_word;
  logic last_beat;

  // Word slots of the held beat; slots beyond RATIO (only when RATIO is not
  // a power of two) are tied off so the select below is always in range.
  logic [OUT_WIDTH-1:0] words [N_SLOTS];

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_words
    if (g < RATIO) begin : g_used
      assign words[g] = hold[g*OUT_WIDTH +: OUT_WIDTH];
    end else begin : g_pad
      assign words[g] = '0;
    end
  end

  assign last_word = (word_idx == LAST_IDX);
  assign last_beat = (beat_cnt == LAST_BEAT);

  assign m_tvalid = hold_valid;
  assign m_tdata  = words[word_idx];
  assign m_tlast  = hold_valid & last_word & last_beat;

  assign s_tready = ~rd_rst & (~hold_valid | (last_word & m_tready));

  assign accept = s_tvalid & s_tready;
  assign fire   = m_tvalid & m_tready;

  assign busy = hold_valid | (beat_cnt != '0);

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      hold_valid <= 1'b0;
      word_idx   <= '0;
      beat_cnt   <= '0;
    end else if (fire) begin
      if (last_word) begin
        word_idx   <= '0;
        beat_cnt   <= last_beat ? '0 : beat_cnt + CNT_W'(1);
        // Refill in the same cycle when a new beat is accepted.
        hold_valid <= accept;
      end else begin
        word_idx <= word_idx + IDX_W'(1);
      end
    end else if (accept) begin
      hold_valid <= 1'b1;
    end
  end

  // Datapath register: only meaningful while hold_valid, so no reset.
  always_ff @(posedge rd_clk) begin
    if (accept) begin
      hold <= s_tdata;
    end
  end

endmodule
